spi_slave_port: RTL

SPI_SLAVE_PORT -- requirements
Module: spi_slave_port

---
 rtl/spi_slave_port_pkg.sv | 16 +
 rtl/spi_slave_port_pin_sync.sv | 39 +++
 rtl/spi_slave_port.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/spi_slave_port_pkg.sv
// Shared constants and types for the SPI mode-0 slave port.
// Holds the frame state encoding and the byte sent when TX has nothing to offer.
package spi_slave_port_pkg;

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  localparam logic [7:0] TX_IDLE_BYTE = 8'hFF;

  typedef struct packed {
    logic level;
    logic rise;
    logic fall;
  } pin_evt_t;

endpackage

// File: rtl/spi_slave_port_pin_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin, plus single-cycle
// rise/fall pulses derived from the synchronized level.
module pin_sync
  import spi_slave_port_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic     clk,
  input  logic     resetn,
  input  logic     pin_i,
  output pin_evt_t evt_o
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], pin_i};
    prev_d = sync_q[STAGES-1];
  end

  // Preloading to 1 makes a pin held low through reset look like a fresh falling edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  always_comb begin
    evt_o.level = sync_q[STAGES-1];
    evt_o.rise  = sync_q[STAGES-1] & ~prev_q;
    evt_o.fall  = ~sync_q[STAGES-1] & prev_q;
  end

endmodule

// File: rtl/spi_slave_port.sv
// SPI mode-0 slave port fully in the clk domain: synchronized pins, byte RX
// with first-byte flag, and a single-entry TX holding register with underrun.
module spi_slave_port
  import spi_slave_port_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       spi_csn_i,
  input  logic       spi_sck_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic [7:0] rx_byte_o,
  output logic       rx_valid_o,
  output logic       rx_first_o,
  input  logic [7:0] tx_byte_i,
  input  logic       tx_load_i,
  output logic       tx_ready_o,
  output logic       tx_underrun_o,
  output logic       sel_o,
  output logic       frame_end_o
);

  pin_evt_t csn_evt, sck_evt, mosi_evt;

  pin_sync #(.STAGES(SYNC_STAGES)) u_csn_sync  (.clk(clk), .resetn(resetn), .pin_i(spi_csn_i),  .evt_o(csn_evt));
  pin_sync #(.STAGES(SYNC_STAGES)) u_sck_sync  (.clk(clk), .resetn(resetn), .pin_i(spi_sck_i),  .evt_o(sck_evt));
  pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (.clk(clk), .resetn(resetn), .pin_i(spi_mosi_i), .evt_o(mosi_evt));

  logic unused_evt;
  assign unused_evt = ^{csn_evt.level, sck_evt.level, mosi_evt.rise, mosi_evt.fall};

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       first_q, first_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_first_q, rx_first_d;
  logic       underrun_q, underrun_d;
  logic       frame_end_q, frame_end_d;
  logic       consume;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    rx_first_d  = 1'b0;
    underrun_d  = 1'b0;
    frame_end_d = 1'b0;
    consume     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (csn_evt.fall) begin
        state_d   = ST_ACTIVE;
        bit_cnt_d = 3'd0;
        first_d   = 1'b1;
        consume   = 1'b1;
      end
    end else if (csn_evt.rise) begin
      state_d     = ST_IDLE;
      bit_cnt_d   = 3'd0;
      rx_shift_d  = TX_IDLE_BYTE;
      frame_end_d = 1'b1;
    end else begin
      if (sck_evt.rise) begin
        rx_shift_d = {rx_shift_q[6:0], mosi_evt.level};
        bit_cnt_d  = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          rx_byte_d  = rx_shift_d;
          rx_valid_d = 1'b1;
          rx_first_d = first_q;
          first_d    = 1'b0;
        end
      end
      // A falling edge with the counter at zero can only follow bit 7.
      if (sck_evt.fall) begin
        if (bit_cnt_q == 3'd0) begin
          consume = 1'b1;
        end else begin
          tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end
      end
    end

    if (consume) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = TX_IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end

    if (tx_load_i && !hold_full_q) begin
      hold_d      = tx_byte_i;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      first_q     <= 1'b0;
      rx_shift_q  <= TX_IDLE_BYTE;
      tx_shift_q  <= TX_IDLE_BYTE;
      hold_q      <= TX_IDLE_BYTE;
      hold_full_q <= 1'b0;
      rx_byte_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      rx_first_q  <= 1'b0;
      underrun_q  <= 1'b0;
      frame_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      rx_first_q  <= rx_first_d;
      underrun_q  <= underrun_d;
      frame_end_q <= frame_end_d;
    end
  end

  assign spi_miso_o    = (state_q == ST_ACTIVE) ? tx_shift_q[7] : 1'b1;
  assign rx_byte_o     = rx_byte_q;
  assign rx_valid_o    = rx_valid_q;
  assign rx_first_o    = rx_first_q;
  assign tx_ready_o    = ~hold_full_q;
  assign tx_underrun_o = underrun_q;
  assign sel_o         = (state_q == ST_ACTIVE);
  assign frame_end_o   = frame_end_q;

endmodule
